// File: rtl/ms_path_packer.sv
// ms_path_packer: turns the solver's coordinate stream into 2-bit moves packed 4 per byte behind a FWFT byte FIFO.
// Inputs: clk, rst, in_valid/in_x/in_y/in_no_path (solver stream, never stalled), out_ready (consumer).
// Outputs: out_valid/out_byte/out_last (FIFO head), done pulse with held path_len/no_path/err summary.
module ms_path_packer #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] in_x,
  input  logic [3:0] in_y,
  input  logic       in_no_path,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_byte,
  output logic       out_last,
  output logic       done,
  output logic [7:0] path_len,
  output logic       no_path,
  output logic       err
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, PATH, FLUSH, NOPATH} state_t;
  state_t state_q;
  logic v_q, np_q, full_q, perr_q, done_q, no_path_q, err_q;
  logic [3:0] x_q, y_q, px_q, py_q;
  logic [7:0] stg_q, len_q, path_len_q;
  logic [1:0] slot_q;
  logic [AW:0] wr_q, rd_q;
  logic [7:0] mem [DEPTH];
  logic [DEPTH-1:0] lmem;
  logic right, left, up, down, adj, move, flush, start, push, empty, fifo_full, pop, wr_en, drop;
  logic [1:0] mv, s, slot_d;
  logic [7:0] stg_d;
  // 5-bit compares so a step off the 0/15 edge is never mistaken for adjacency
  assign right = {1'b0, x_q} == {1'b0, px_q} + 5'd1 && y_q == py_q;
  assign left = {1'b0, x_q} + 5'd1 == {1'b0, px_q} && y_q == py_q;
  assign up = {1'b0, y_q} + 5'd1 == {1'b0, py_q} && x_q == px_q;
  assign down = {1'b0, y_q} == {1'b0, py_q} + 5'd1 && x_q == px_q;
  assign adj = right | left | up | down;
  assign mv = down ? 2'd3 : up ? 2'd2 : left ? 2'd1 : 2'd0;
  assign move = state_q == PATH && v_q;
  assign flush = state_q == FLUSH;
  assign start = v_q && (state_q == IDLE || state_q == FLUSH);
  // a completed byte waits in staging (full_q) so the final one can be marked last at flush
  assign s = full_q ? 2'd0 : slot_q;
  assign slot_d = s + 2'd1;
  assign stg_d = (full_q ? 8'h00 : stg_q) | (8'(mv) << {s, 1'b0});
  assign push = (move && full_q) || (flush && (full_q || slot_q != 2'd0));
  assign empty = wr_q == rd_q;
  assign fifo_full = wr_q[AW] != rd_q[AW] && wr_q[AW-1:0] == rd_q[AW-1:0];
  assign pop = out_valid && out_ready;
  assign wr_en = push && (!fifo_full || pop);
  assign drop = push && !wr_en;
  assign out_valid = !empty;
  assign out_byte = empty ? 8'h00 : mem[rd_q[AW-1:0]];
  assign out_last = !empty && lmem[rd_q[AW-1:0]];
  assign done = done_q;
  assign path_len = path_len_q;
  assign no_path = no_path_q;
  assign err = err_q;
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_q[AW-1:0]] <= stg_q;
      lmem[wr_q[AW-1:0]] <= flush;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      {v_q, np_q, x_q, y_q, px_q, py_q} <= '0;
      {stg_q, slot_q, full_q, perr_q, len_q} <= '0;
      {wr_q, rd_q} <= '0;
      {done_q, path_len_q, no_path_q, err_q} <= '0;
    end else begin
      v_q <= in_valid;
      np_q <= in_no_path;
      x_q <= in_x;
      y_q <= in_y;
      done_q <= 1'b0;
      if (wr_en) wr_q <= wr_q + (AW+1)'(1);
      if (pop) rd_q <= rd_q + (AW+1)'(1);
      if (flush) begin
        done_q <= 1'b1;
        path_len_q <= len_q;
        no_path_q <= 1'b0;
        err_q <= perr_q | drop;
      end
      if (state_q == NOPATH) begin
        done_q <= 1'b1;
        path_len_q <= 8'd0;
        no_path_q <= 1'b1;
        err_q <= 1'b0;
      end
      if (start) begin
        {px_q, py_q} <= {x_q, y_q};
        {stg_q, slot_q, full_q, perr_q, len_q} <= '0;
        state_q <= np_q ? NOPATH : PATH;
      end else if (move) begin
        {px_q, py_q} <= {x_q, y_q};
        stg_q <= stg_d;
        slot_q <= slot_d;
        full_q <= s == 2'd3;
        len_q <= len_q + 8'(~&len_q);
        perr_q <= perr_q | ~adj | (&len_q) | drop;
      end else begin
        state_q <= state_q == PATH ? FLUSH : IDLE;
      end
    end
  end
endmodule

// File: tb/tb_ms_path_packer.sv
// tb_ms_path_packer: directed paths checked against a coordinate-level packing model plus literal pins.
module tb_ms_path_packer;
  localparam int DEPTH = 16;
  logic clk = 0, rst = 1, in_valid = 0, in_no_path = 0, out_ready = 1;
  logic [3:0] in_x = 0, in_y = 0;
  logic out_valid, out_last, done, no_path, err;
  logic [7:0] out_byte, path_len;
  int total = 0, bad = 0;
  int cx [80], cy [80];
  bit cnp [80];
  logic [8:0] exp_b [$];
  logic [9:0] exp_s [$];
  logic [8:0] got_log [$];

  ms_path_packer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_x(in_x), .in_y(in_y),
    .in_no_path(in_no_path), .out_valid(out_valid), .out_ready(out_ready),
    .out_byte(out_byte), .out_last(out_last), .done(done), .path_len(path_len),
    .no_path(no_path), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_c(input int i, input int x, input int y, input bit np);
    cx[i] = x;
    cy[i] = y;
    cnp[i] = np;
  endtask

  // Expected bytes and summary straight from the move/packing rules
  task automatic model_path(input int n, input bit stall);
    logic [8:0] bytes [$];
    logic [7:0] cur = 0;
    int len = 0, k = 0, dx, dy, code;
    bit e = 0;
    if (cnp[0]) begin
      exp_s.push_back({8'd0, 1'b1, 1'b0});
      return;
    end
    for (int i = 1; i < n; i++) begin
      dx = cx[i] - cx[i-1];
      dy = cy[i] - cy[i-1];
      if (dx == 1 && dy == 0) code = 0;
      else if (dx == -1 && dy == 0) code = 1;
      else if (dx == 0 && dy == -1) code = 2;
      else if (dx == 0 && dy == 1) code = 3;
      else begin code = 0; e = 1; end
      if (len == 255) e = 1; else len++;
      cur = cur | 8'(code << (2 * (k % 4)));
      if (k % 4 == 3) begin bytes.push_back({1'b0, cur}); cur = 0; end
      k++;
    end
    if (k % 4 != 0) bytes.push_back({1'b0, cur});
    if (bytes.size() > 0) bytes[bytes.size()-1][8] = 1'b1;
    if (stall && bytes.size() > DEPTH) begin
      e = 1;
      while (bytes.size() > DEPTH) void'(bytes.pop_back());
    end
    foreach (bytes[i]) exp_b.push_back(bytes[i]);
    exp_s.push_back({8'(len), 1'b0, e});
  endtask

  task automatic drive_path(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1;
      in_x = 4'(cx[i]);
      in_y = 4'(cy[i]);
      in_no_path = cnp[i];
      step();
    end
    in_valid = 0;
    in_no_path = 0;
  endtask

  task automatic wait_done();
    int c = 0;
    while ((exp_s.size() != 0 || (out_ready && exp_b.size() != 0)) && c < 60) begin
      step();
      c++;
    end
    chk("done_timeout", 32'(exp_s.size()), 0);
    repeat (2) step();
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        total++;
        got_log.push_back({out_last, out_byte});
        if (exp_b.size() == 0) begin
          bad++;
          $display("FAIL unexpected_byte got=%0h", {out_last, out_byte});
        end else if ({out_last, out_byte} !== exp_b[0]) begin
          bad++;
          $display("FAIL byte got=%0h exp=%0h", {out_last, out_byte}, exp_b[0]);
          void'(exp_b.pop_front());
        end else void'(exp_b.pop_front());
      end
      if (done) begin
        total++;
        if (exp_s.size() == 0) begin
          bad++;
          $display("FAIL unexpected_done got=%0h", {path_len, no_path, err});
        end else if ({path_len, no_path, err} !== exp_s[0]) begin
          bad++;
          $display("FAIL summary got=%0h exp=%0h", {path_len, no_path, err}, exp_s[0]);
          void'(exp_s.pop_front());
        end else void'(exp_s.pop_front());
      end
    end
  end

  initial begin
    int x, y, nx, ny, d;
    repeat (3) step();
    @(negedge clk);
    chk("reset_outs", {out_valid, out_byte, out_last, done, path_len, no_path, err}, 0);
    @(posedge clk);
    #1 rst = 0;
    // Mixed LEFT/UP path; no_path on a later coordinate must be ignored
    set_c(0, 14, 14, 0); set_c(1, 13, 14, 0); set_c(2, 13, 13, 1);
    set_c(3, 12, 13, 0); set_c(4, 12, 12, 0); set_c(5, 11, 12, 0);
    got_log.delete();
    model_path(6, 0);
    chk("model_b0", 32'(exp_b[0]), 9'h099);
    drive_path(6);
    wait_done();
    chk("t1_nbytes", 32'(got_log.size()), 2);
    chk("t1_b0", 32'(got_log[0]), 9'h099);
    chk("t1_b1", 32'(got_log[1]), 9'h101);
    chk("t1_sum", {path_len, no_path, err}, {8'd5, 2'b00});
    // Eight RIGHT moves: the full second byte must be marked last at flush
    for (int i = 0; i < 9; i++) set_c(i, i, 0, 0);
    got_log.delete();
    model_path(9, 0);
    drive_path(9);
    wait_done();
    chk("t2_nbytes", 32'(got_log.size()), 2);
    chk("t2_b1", 32'(got_log[1]), 9'h100);
    chk("t2_len", path_len, 8);
    // No-path single strobe
    set_c(0, 7, 7, 1);
    got_log.delete();
    model_path(1, 0);
    drive_path(1);
    wait_done();
    chk("t3_nbytes", 32'(got_log.size()), 0);
    chk("t3_sum", {path_len, no_path, err}, {8'd0, 2'b10});
    // Non-adjacent step encodes 0 and sets err
    set_c(0, 5, 5, 0); set_c(1, 7, 5, 0); set_c(2, 7, 6, 0);
    got_log.delete();
    model_path(3, 0);
    drive_path(3);
    wait_done();
    chk("t4_b0", 32'(got_log[0]), 9'h10C);
    chk("t4_sum", {path_len, no_path, err}, {8'd2, 2'b01});
    // Back-to-back paths separated by one idle cycle (FLUSH -> PATH)
    set_c(0, 3, 3, 0); set_c(1, 4, 3, 0); set_c(2, 4, 4, 0);
    got_log.delete();
    model_path(3, 0);
    drive_path(3);
    step();
    set_c(0, 0, 0, 0); set_c(1, 0, 1, 0);
    model_path(2, 0);
    drive_path(2);
    wait_done();
    chk("t5_nbytes", 32'(got_log.size()), 2);
    chk("t5_b1", 32'(got_log[1]), 9'h103);
    chk("t5_len", path_len, 1);
    // 70-move path with the consumer stalled: FIFO keeps the first DEPTH bytes
    out_ready = 0;
    x = 0; y = 0;
    set_c(0, 0, 0, 0);
    for (int i = 1; i <= 70; i++) begin
      d = (i * 5 + i / 3) % 4;
      nx = x + (d == 0) - (d == 1);
      ny = y + (d == 3) - (d == 2);
      if (nx < 0 || nx > 15 || ny < 0 || ny > 15) begin
        nx = x - (d == 0) + (d == 1);
        ny = y - (d == 3) + (d == 2);
      end
      x = nx; y = ny;
      set_c(i, x, y, 0);
    end
    got_log.delete();
    model_path(71, 1);
    chk("model_stall_n", 32'(exp_b.size()), DEPTH);
    drive_path(71);
    wait_done();
    chk("t6_sum", {path_len, no_path, err}, {8'd70, 2'b01});
    chk("t6_held", out_valid, 1);
    out_ready = 1;
    wait_done();
    chk("t6_drained", 32'(got_log.size()), DEPTH);
    chk("t6_empty", out_valid, 0);
    // Reset mid-path: no done, everything back to reset values
    set_c(0, 1, 1, 0); set_c(1, 2, 1, 0); set_c(2, 2, 2, 0);
    got_log.delete();
    drive_path(3);
    rst = 1;
    repeat (2) step();
    @(negedge clk);
    chk("t7_reset_outs", {out_valid, out_byte, out_last, done, path_len, no_path, err}, 0);
    @(posedge clk);
    #1 rst = 0;
    set_c(0, 14, 14, 0); set_c(1, 13, 14, 0); set_c(2, 13, 13, 0);
    set_c(3, 12, 13, 0); set_c(4, 12, 12, 0); set_c(5, 11, 12, 0);
    model_path(6, 0);
    drive_path(6);
    wait_done();
    chk("t7_nbytes", 32'(got_log.size()), 2);
    chk("t7_b0", 32'(got_log[0]), 9'h099);
    chk("t7_len", path_len, 5);
    chk("left_bytes", 32'(exp_b.size()), 0);
    chk("left_sums", 32'(exp_s.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
